// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with frame-stable player position
// One clock per pixel; all outputs registered from the pre-increment counter state.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PLAYER_X0 = 320,
  parameter int PLAYER_Y0 = 240
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic       player_in_valid,
  input  logic [9:0] player_in_x,
  input  logic [8:0] player_in_y,
  output logic [9:0] CurrentX,
  output logic [8:0] CurrentY,
  output logic       HBlank,
  output logic       VBlank,
  output logic       HSync,
  output logic       VSync,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic [9:0] playerPosX,
  output logic [8:0] playerPosY
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] X_MAX     = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_MAX     = 9'(V_ACTIVE - 1);
  localparam logic [9:0] X_RST     = 10'(PLAYER_X0);
  localparam logic [8:0] Y_RST     = 9'(PLAYER_Y0);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       fs_q, fs_d;
  logic [7:0] fc_q, fc_d;
  logic       first_q, first_d;
  logic [9:0] pend_x_q, pend_x_d;
  logic [8:0] pend_y_q, pend_y_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [8:0] pos_y_q, pos_y_d;
  logic [9:0] in_x_clamped;
  logic [8:0] in_y_clamped;

  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end

    hblank_d = (h_cnt_q >= H_ACT);
    vblank_d = (v_cnt_q >= V_ACT);
    hsync_d  = !((h_cnt_q >= H_SYNC_LO) && (h_cnt_q <= H_SYNC_HI));
    vsync_d  = !((v_cnt_q >= V_SYNC_LO) && (v_cnt_q <= V_SYNC_HI));
    x_d      = (!hblank_d && !vblank_d) ? h_cnt_q : 10'd0;
    y_d      = (!hblank_d && !vblank_d) ? v_cnt_q[8:0] : 9'd0;

    // The pulse that opens the first frame after reset does not count a completed frame.
    fs_d     = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    fc_d     = (fs_d && !first_q) ? fc_q + 8'd1 : fc_q;
    first_d  = first_q && !fs_d;

    in_x_clamped = (player_in_x > X_MAX) ? X_MAX : player_in_x;
    in_y_clamped = (player_in_y > Y_MAX) ? Y_MAX : player_in_y;
    pend_x_d     = player_in_valid ? in_x_clamped : pend_x_q;
    pend_y_d     = player_in_valid ? in_y_clamped : pend_y_q;
    // Publishing pend_*_d gives the same-edge bypass for free.
    pos_x_d      = fs_d ? pend_x_d : pos_x_q;
    pos_y_d      = fs_d ? pend_y_d : pos_y_q;
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q  <= 10'd0;
      v_cnt_q  <= 10'd0;
      x_q      <= 10'd0;
      y_q      <= 9'd0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fs_q     <= 1'b0;
      fc_q     <= 8'd0;
      first_q  <= 1'b1;
      pend_x_q <= X_RST;
      pend_y_q <= Y_RST;
      pos_x_q  <= X_RST;
      pos_y_q  <= Y_RST;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
      fc_q     <= fc_d;
      first_q  <= first_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
    end
  end

  assign CurrentX    = x_q;
  assign CurrentY    = y_q;
  assign HBlank      = hblank_q;
  assign VBlank      = vblank_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;
  assign playerPosX  = pos_x_q;
  assign playerPosY  = pos_y_q;

endmodule
